// File: rtl/instr_decode_pipe.sv
// Purpose: registers one MPU instruction behind valid/ready and decodes it, with wrong-path squash after taken jumps.
// Latency: an instruction accepted on edge N is presented (out_valid, decode) from edge N onward.
// Backpressure: stall holds a live instruction in place and drops in_ready; otherwise one instruction per cycle.
module instr_decode_pipe #(
  parameter int unsigned SQUASH = 1,   // wrong-path instructions dropped after a taken jump (0..3)
  parameter int unsigned CNT_W  = 16   // performance counter width
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             jmp_taken,
  output logic             out_valid,
  output logic [7:0]       ir,
  output logic [8:0]       reg_en,
  output logic [3:0]       source_sel,
  output logic             i_sel,
  output logic             x_sel,
  output logic             y_sel,
  output logic             jmp,
  output logic             jmp_nz,
  output logic [3:0]       ir_nibble,
  output logic             nop_hit,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] nop_count
);

  localparam logic [1:0]       SQ_LOAD = 2'(SQUASH);
  localparam logic [3:0]       SRC_PM_DATA = 4'd8;
  localparam logic [3:0]       SRC_I_PINS  = 4'd9;
  localparam logic [3:0]       SRC_NONE    = 4'd10;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // Register code 4 is r when read but o_reg when written, so its enable lives in bit 8.
  function automatic logic [8:0] dest_mask(input logic [2:0] d);
    if (d == 3'd4) dest_mask = 9'h100;
    else           dest_mask = 9'h001 << d;
  endfunction

  logic [7:0]       ir_q, ir_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       squash_cnt_q, squash_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] nop_cnt_q, nop_cnt_d;

  logic             accept, retire, squash_trig;

  // Raw decode of the register before gating by out_valid.
  logic [8:0]       re_raw;
  logic [3:0]       ss_raw;
  logic             isel_raw, xsel_raw, ysel_raw, jmp_raw, jnz_raw, nop_raw;
  logic [2:0]       dst, src;

  // Combinational decode of the instruction register.
  always_comb begin
    re_raw   = 9'h000;
    ss_raw   = SRC_NONE;
    isel_raw = 1'b0;
    xsel_raw = 1'b0;
    ysel_raw = 1'b0;
    dst      = 3'd0;
    src      = 3'd0;
    jmp_raw  = (ir_q[7:4] == 4'b1110);
    jnz_raw  = (ir_q[7:4] == 4'b1111);
    nop_raw  = (ir_q == 8'hC8) || (ir_q == 8'hCF) || (ir_q == 8'hD8) || (ir_q == 8'hDF);
    if (!ir_q[7]) begin
      // load 0dddnnnn: immediate comes from program memory
      dst    = ir_q[6:4];
      re_raw = dest_mask(dst);
      ss_raw = SRC_PM_DATA;
      if (dst == 3'd7) begin
        re_raw[6] = 1'b1;
        isel_raw  = 1'b1;
      end
    end else if (ir_q[7:6] == 2'b10) begin
      // mov 10dddsss: dm accesses are addressed through i, so i is touched too
      dst    = ir_q[5:3];
      src    = ir_q[2:0];
      re_raw = dest_mask(dst);
      if (dst == 3'd7 || (src == 3'd7 && dst != 3'd6)) begin
        re_raw[6] = 1'b1;
        isel_raw  = 1'b1;
      end
      // mov r->o_reg is a real move; any other self-move reads the input pins
      if (dst == 3'd4 && src == 3'd4) ss_raw = 4'd4;
      else if (dst == src)            ss_raw = SRC_I_PINS;
      else                            ss_raw = {1'b0, src};
    end else if (ir_q[7:5] == 3'b110) begin
      // ALU 110xyfff: result always lands in r
      re_raw[4] = 1'b1;
      xsel_raw  = ir_q[4];
      ysel_raw  = ir_q[3];
    end
  end

  // Gate every decode output while the register does not hold a live instruction.
  always_comb begin
    out_valid  = out_valid_q;
    ir         = ir_q;
    ir_nibble  = ir_q[3:0];
    reg_en     = out_valid_q ? re_raw   : 9'h000;
    source_sel = out_valid_q ? ss_raw   : SRC_NONE;
    i_sel      = out_valid_q & isel_raw;
    x_sel      = out_valid_q & xsel_raw;
    y_sel      = out_valid_q & ysel_raw;
    jmp        = out_valid_q & jmp_raw;
    jmp_nz     = out_valid_q & jnz_raw;
    nop_hit    = out_valid_q & nop_raw;
    retire_count = retire_cnt_q;
    nop_count    = nop_cnt_q;
  end

  // Handshake, squash and pipeline-register next state.
  always_comb begin
    in_ready     = !out_valid_q || !stall;
    accept       = in_valid && in_ready;
    retire       = out_valid_q && !stall;
    squash_trig  = retire && (jmp || jmp_nz) && jmp_taken;
    ir_d         = ir_q;
    out_valid_d  = out_valid_q;
    squash_cnt_d = squash_cnt_q;
    if (squash_trig) squash_cnt_d = SQ_LOAD;
    if (accept) begin
      // An instruction accepted in the trigger cycle is already on the wrong path.
      ir_d = instr;
      if (squash_cnt_d == 2'd0) begin
        out_valid_d = 1'b1;
      end else begin
        out_valid_d  = 1'b0;
        squash_cnt_d = squash_cnt_d - 2'd1;
      end
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating retire and NOP counters.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    nop_cnt_d    = nop_cnt_q;
    if (retire && !(&retire_cnt_q))          retire_cnt_d = retire_cnt_q + CNT_ONE;
    if (retire && nop_raw && !(&nop_cnt_q))  nop_cnt_d    = nop_cnt_q + CNT_ONE;
  end

  // State registers; reset discards any pending instruction and squash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q         <= 8'h00;
      out_valid_q  <= 1'b0;
      squash_cnt_q <= 2'd0;
      retire_cnt_q <= '0;
      nop_cnt_q    <= '0;
    end else begin
      ir_q         <= ir_d;
      out_valid_q  <= out_valid_d;
      squash_cnt_q <= squash_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      nop_cnt_q    <= nop_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe: expected decodes queued at issue, compared on retire.
// Main DUT uses SQUASH=1, CNT_W=8 so saturation is reachable; a SQUASH=0 copy shows jumps are inert there.
// Stall/backpressure, squash, reset-during-stall and counter saturation are exercised by directed vectors.
module tb_instr_decode_pipe;

  typedef struct packed {
    logic [7:0] ir;
    logic [8:0] re;
    logic [3:0] ss;
    logic [5:0] fl;  // {i_sel, x_sel, y_sel, jmp, jmp_nz, nop_hit}
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n, in_valid, stall, jmp_taken;
  logic [7:0] instr;

  logic       in_ready, out_valid, i_sel, x_sel, y_sel, jmp, jmp_nz, nop_hit;
  logic [7:0] ir;
  logic [8:0] reg_en;
  logic [3:0] source_sel, ir_nibble;
  logic [7:0] retire_count, nop_count;

  logic       z_in_ready, z_out_valid, z_i_sel, z_x_sel, z_y_sel, z_jmp, z_jmp_nz, z_nop_hit;
  logic [7:0] z_ir;
  logic [8:0] z_reg_en;
  logic [3:0] z_source_sel, z_ir_nibble;
  logic [7:0] z_retire_count, z_nop_count;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] rc0;

  always #5 clk = ~clk;

  instr_decode_pipe #(.SQUASH(1), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .jmp_taken(jmp_taken), .out_valid(out_valid), .ir(ir), .reg_en(reg_en),
    .source_sel(source_sel), .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel), .jmp(jmp),
    .jmp_nz(jmp_nz), .ir_nibble(ir_nibble), .nop_hit(nop_hit),
    .retire_count(retire_count), .nop_count(nop_count)
  );

  instr_decode_pipe #(.SQUASH(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .instr(instr), .in_valid(in_valid), .in_ready(z_in_ready),
    .stall(stall), .jmp_taken(jmp_taken), .out_valid(z_out_valid), .ir(z_ir), .reg_en(z_reg_en),
    .source_sel(z_source_sel), .i_sel(z_i_sel), .x_sel(z_x_sel), .y_sel(z_y_sel), .jmp(z_jmp),
    .jmp_nz(z_jmp_nz), .ir_nibble(z_ir_nibble), .nop_hit(z_nop_hit),
    .retire_count(z_retire_count), .nop_count(z_nop_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t V(input logic [7:0] i, input logic [8:0] re, input logic [3:0] ss,
                             input logic [5:0] fl);
    V = '{ir: i, re: re, ss: ss, fl: fl};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t e, input bit live);
    instr    = e.ir;
    in_valid = 1'b1;
    if (live) q.push_back(e);
    cyc();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Monitor: every retiring instruction must match the next queued expectation.
  always @(negedge clk) begin : monitor
    exp_t a, e;
    if (reset_n && out_valid && !stall) begin
      a.ir = ir; a.re = reg_en; a.ss = source_sel;
      a.fl = {i_sel, x_sel, y_sel, jmp, jmp_nz, nop_hit};
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_retire: got ir %h, expected no live instruction", ir);
      end else begin
        e = q.pop_front();
        chk($sformatf("decode_%h", e.ir), 32'(a), 32'(e));
        chk($sformatf("nibble_%h", e.ir), 32'(ir_nibble), 32'(e.ir[3:0]));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0; jmp_taken = 1'b0; instr = 8'h00;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_reg_en", 32'(reg_en), 0);
    chk("rst_source_sel", 32'(source_sel), 10);
    chk("rst_counts", {16'h0, retire_count, nop_count}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back stream with no stall.
    send(V(8'h10, 9'h002, 4'd8, 6'b000000), 1);
    chk("first_edge_valid", 32'(out_valid), 1);
    send(V(8'h25, 9'h004, 4'd8, 6'b000000), 1);
    send(V(8'h83, 9'h001, 4'd3, 6'b000000), 1);
    send(V(8'hD0, 9'h010, 4'd10, 6'b010000), 1);
    idle(1);
    chk("stream_retire_count", 32'(retire_count), 4);

    // mov dm->dm held by a three-cycle stall with the next instruction waiting.
    send(V(8'hBF, 9'h0C0, 4'd9, 6'b100000), 1);
    stall = 1'b1;
    instr = 8'h9F;
    in_valid = 1'b1;
    #1;
    chk("stall_in_ready", 32'(in_ready), 0);
    rc0 = retire_count;
    repeat (3) begin
      cyc();
      chk("stall_ir_hold", 32'(ir), 32'h BF);
      chk("stall_count_hold", 32'(retire_count), 32'(rc0));
      chk("stall_in_ready_hold", 32'(in_ready), 0);
    end
    stall = 1'b0;
    q.push_back(V(8'h9F, 9'h048, 4'd7, 6'b100000));
    cyc();
    chk("unstall_retire_once", 32'(retire_count), 32'(rc0 + 8'd1));
    chk("unstall_accept", 32'(ir), 32'h9F);
    idle(1);
    chk("unstall_retire_next", 32'(retire_count), 32'(rc0 + 8'd2));

    // Taken jump squashes the instruction accepted in the same cycle.
    rc0 = retire_count;
    send(V(8'hE5, 9'h000, 4'd10, 6'b000100), 1);
    jmp_taken = 1'b1;
    send(V(8'h10, 9'h002, 4'd8, 6'b000000), 0);
    jmp_taken = 1'b0;
    chk("squash_out_valid", 32'(out_valid), 0);
    chk("squash_ir_loaded", 32'(ir), 32'h10);
    chk("squash_reg_en_off", 32'(reg_en), 0);
    chk("squash_src_none", 32'(source_sel), 10);
    chk("nosquash_valid", 32'(z_out_valid), 1);
    send(V(8'h20, 9'h004, 4'd8, 6'b000000), 1);
    idle(1);
    chk("squash_retire_count", 32'(retire_count), 32'(rc0 + 8'd2));

    // jmp_taken is ignored unless a jump retires; more decode corners.
    jmp_taken = 1'b1;
    send(V(8'h70, 9'h0C0, 4'd8, 6'b100000), 1);
    send(V(8'hA3, 9'h100, 4'd3, 6'b000000), 1);
    send(V(8'hA4, 9'h100, 4'd4, 6'b000000), 1);
    send(V(8'hB7, 9'h040, 4'd7, 6'b000000), 1);
    jmp_taken = 1'b0;
    send(V(8'hF3, 9'h000, 4'd10, 6'b000010), 1);
    send(V(8'h00, 9'h001, 4'd8, 6'b000000), 1);
    idle(1);

    // NOP encodings.
    rc0 = retire_count;
    send(V(8'hC8, 9'h010, 4'd10, 6'b001001), 1);
    send(V(8'hCF, 9'h010, 4'd10, 6'b001001), 1);
    send(V(8'hD8, 9'h010, 4'd10, 6'b011001), 1);
    send(V(8'hDF, 9'h010, 4'd10, 6'b011001), 1);
    send(V(8'hC0, 9'h010, 4'd10, 6'b000000), 1);
    idle(1);
    chk("nop_count", 32'(nop_count), 4);
    chk("nop_retire_count", 32'(retire_count), 32'(rc0 + 8'd5));

    // Asynchronous reset while a stall holds 84.
    send(V(8'h84, 9'h001, 4'd4, 6'b000000), 0);
    stall = 1'b1;
    in_valid = 1'b0;
    cyc();
    chk("pre_reset_valid", 32'(out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_counts", {16'h0, retire_count, nop_count}, 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    #4;
    reset_n = 1'b1;
    stall = 1'b0;
    cyc();
    send(V(8'h84, 9'h001, 4'd4, 6'b000000), 1);
    chk("post_reset_valid", 32'(out_valid), 1);
    idle(1);
    chk("post_reset_count", 32'(retire_count), 1);

    // Saturation of the retire counter.
    for (int k = 0; k < 254; k++) send(V(8'h00, 9'h001, 4'd8, 6'b000000), 1);
    idle(1);
    chk("count_at_max", 32'(retire_count), 32'hFF);
    send(V(8'h00, 9'h001, 4'd8, 6'b000000), 1);
    idle(2);
    chk("count_saturated", 32'(retire_count), 32'hFF);
    chk("queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
